// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share one ALU. At most one operation is accepted per
// cycle. Contention is resolved round-robin. The accepted operation is
// evaluated combinationally and captured in a single-entry result register
// that is drained through a valid/ready handshake. Each requester has a
// saturating count of its accepted operations.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   req0_valid / req1_valid  requester k presents an operation
//   req0_ready / req1_ready  requester k's operation accepted this cycle
//   req0_a, req0_b           requester 0 operands (N bits)
//   req1_a, req1_b           requester 1 operands (N bits)
//   req0_op / req1_op        operation select (4 bits)
//   resp_valid               result register holds a valid result
//   resp_ready               consumer takes the result this cycle
//   resp_id                  requester that issued the held result
//   resp_result              ALU result (N bits)
//   resp_ovf                 bit0 unsigned carry/borrow, bit1 signed overflow
//   resp_illegal             held result came from an unsupported op
//   grant_cnt0 / grant_cnt1  saturating accepted-operation counters
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req0_op,
    input  logic [3:0]   req1_op,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_result,
    output logic [1:0]   resp_ovf,
    output logic         resp_illegal,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic         last_grant;   // requester granted on the most recent accept
    logic         grant;        // requester selected this cycle
    logic         can_accept;
    logic         accept;

    logic [3:0]   sel_op;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;

    logic [N:0]   sum_ext;
    logic [N-1:0] diff;
    logic [N-1:0] alu_res;
    logic [1:0]   alu_ovf;
    logic         alu_ill;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // A full register can take a new result only when it is being drained
    // in the same cycle.
    assign can_accept = (state_q == EMPTY) || resp_ready;

    // rst_n gating keeps both ready outputs low for the whole reset interval,
    // not just until the asynchronous clear settles.
    assign req0_ready = rst_n && can_accept && req0_valid && (grant == 1'b0);
    assign req1_ready = rst_n && can_accept && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    // ------------------------------------------------------------------
    // ALU on the granted requester's operands
    // ------------------------------------------------------------------
    assign sel_op = grant ? req1_op : req0_op;
    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;

    assign sum_ext = {1'b0, sel_a} + {1'b0, sel_b};
    assign diff    = sel_a - sel_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = '0;
        alu_ill = 1'b0;
        case (sel_op)
            OP_AND: begin
                alu_res = sel_a & sel_b;
            end
            OP_OR: begin
                alu_res = sel_a | sel_b;
            end
            OP_ADD: begin
                alu_res    = sum_ext[N-1:0];
                alu_ovf[0] = sum_ext[N];
                alu_ovf[1] = (sel_a[N-1] == sel_b[N-1]) &&
                             (sum_ext[N-1] != sel_a[N-1]);
            end
            OP_SUB: begin
                alu_res    = diff;
                alu_ovf[0] = (sel_a < sel_b);
                alu_ovf[1] = (sel_a[N-1] != sel_b[N-1]) &&
                             (diff[N-1] != sel_a[N-1]);
            end
            default: begin
                alu_ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (resp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign resp_valid = (state_q == FULL);

    // Payload loads only on accept, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_id      <= 1'b0;
            resp_result  <= '0;
            resp_ovf     <= '0;
            resp_illegal <= 1'b0;
        end else if (accept) begin
            resp_id      <= grant;
            resp_result  <= alu_res;
            resp_ovf     <= alu_ovf;
            resp_illegal <= alu_ill;
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    // ------------------------------------------------------------------
    // Saturating grant counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (req1_ready && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter (N=32). Combines a fixed vector table,
// hand-written multi-cycle sequences (alternation, stall, async reset,
// counter saturation) and randomized traffic against a transaction-level
// reference model.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic          req1_valid;
    logic          req0_ready;
    logic          req1_ready;
    logic [N-1:0]  req0_a;
    logic [N-1:0]  req0_b;
    logic [N-1:0]  req1_a;
    logic [N-1:0]  req1_b;
    logic [3:0]    req0_op;
    logic [3:0]    req1_op;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_id;
    logic [N-1:0]  resp_result;
    logic [1:0]    resp_ovf;
    logic          resp_illegal;
    logic [15:0]   grant_cnt0;
    logic [15:0]   grant_cnt1;

    alu_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_op      (req0_op),
        .req1_op      (req1_op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_ovf     (resp_ovf),
        .resp_illegal (resp_illegal),
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one held response slot, last-winner memory,
    // integer grant totals clipped at 65535.
    // ------------------------------------------------------------------
    bit          m_valid;
    bit          m_id;
    logic [31:0] m_res;
    logic [1:0]  m_ovf;
    bit          m_ill;
    int          m_last;
    int          m_cnt0;
    int          m_cnt1;

    function automatic void model_reset();
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_res   = '0;
        m_ovf   = '0;
        m_ill   = 1'b0;
        m_last  = 1;
        m_cnt0  = 0;
        m_cnt1  = 0;
    endfunction

    // ALU semantics from plain wide integer arithmetic: carry/borrow from
    // the unsigned 64-bit result, overflow from the signed range.
    function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [1:0] o, output bit ill);
        longint ua, ub, sa, sb, t;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        o   = '0;
        ill = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                t    = ua + ub;
                r    = 32'(t);
                o[0] = (t > 64'sd4294967295);
                t    = sa + sb;
                o[1] = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'h6: begin
                t    = ua - ub;
                r    = 32'(t);
                o[0] = (ua < ub);
                t    = sa - sb;
                o[1] = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // One clock cycle. Entered just after a falling edge with inputs set.
    task automatic cycle(input bit do_chk);
        bit          can, e0, e1;
        int          g;
        logic [3:0]  op;
        logic [31:0] a, b;
        #1;
        can = !m_valid || resp_ready;
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else                          g = req1_valid ? 1 : 0;
        e0 = can && req0_valid && (g == 0);
        e1 = can && req1_valid && (g == 1);
        op = (g == 1) ? req1_op : req0_op;
        a  = (g == 1) ? req1_a  : req0_a;
        b  = (g == 1) ? req1_b  : req0_b;
        if (do_chk) begin
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
        end
        @(posedge clk);
        if (e0 || e1) begin
            m_valid = 1'b1;
            m_id    = (g == 1);
            alu_ref(op, a, b, m_res, m_ovf, m_ill);
            m_last  = g;
            if (g == 0 && m_cnt0 < 65535) m_cnt0++;
            if (g == 1 && m_cnt1 < 65535) m_cnt1++;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        if (do_chk) begin
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_result", 64'(resp_result), 64'(m_res));
                chk("resp_ovf", 64'(resp_ovf), 64'(m_ovf));
                chk("resp_illegal", 64'(resp_illegal), 64'(m_ill));
            end
            chk("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
            chk("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 9))
            0, 1: return 4'h0;
            2, 3: return 4'h1;
            4, 5: return 4'h2;
            6, 7: return 4'h6;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  ovf;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 2'b10, 1'b0};
        vecs[1] = '{1'b1, 4'h6, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 2'b01, 1'b0};
        vecs[2] = '{1'b0, 4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2'b01, 1'b0};
        vecs[3] = '{1'b1, 4'h0, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 2'b00, 1'b0};
        vecs[4] = '{1'b0, 4'h1, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 2'b00, 1'b0};
        vecs[5] = '{1'b1, 4'hF, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 2'b00, 1'b1};
        vecs[6] = '{1'b0, 4'h6, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 2'b10, 1'b0};
        vecs[7] = '{1'b1, 4'h6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 2'b00, 1'b0};
        vecs[8] = '{1'b0, 4'h3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 2'b00, 1'b1};
        vecs[9] = '{1'b1, 4'h2, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2'b11, 1'b0};

        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        req0_op    = '0;
        req1_op    = '0;
        resp_ready = 1'b0;
        model_reset();

        // Reset state, with both requesters asking during reset.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_req1_ready", 64'(req1_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_result", 64'(resp_result), 64'd0);
        chk("rst_resp_ovf", 64'(resp_ovf), 64'd0);
        chk("rst_resp_illegal", 64'(resp_illegal), 64'd0);
        chk("rst_cnt0", 64'(grant_cnt0), 64'd0);
        chk("rst_cnt1", 64'(grant_cnt1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;

        // Vector table: one requester at a time, result next cycle.
        foreach (vecs[i]) begin
            req0_valid = (vecs[i].id == 1'b0);
            req1_valid = (vecs[i].id == 1'b1);
            req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
            req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
            cycle(1);
            chk("tbl_valid", 64'(resp_valid), 64'd1);
            chk("tbl_id", 64'(resp_id), 64'(vecs[i].id));
            chk("tbl_result", 64'(resp_result), 64'(vecs[i].res));
            chk("tbl_ovf", 64'(resp_ovf), 64'(vecs[i].ovf));
            chk("tbl_illegal", 64'(resp_illegal), 64'(vecs[i].ill));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle(1);
        chk("drain_valid", 64'(resp_valid), 64'd0);

        // Alternation from reset with both requesting every cycle.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        req0_op = 4'h2;
        req1_op = 4'h6;
        for (int k = 0; k < 6; k++) begin
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            cycle(1);
            chk("alt_id", 64'(resp_id), 64'(k % 2));
        end
        chk("alt_cnt0", 64'(grant_cnt0), 64'd3);
        chk("alt_cnt1", 64'(grant_cnt1), 64'd3);

        // Stall while full, then back-to-back accept on release.
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req0_a = $urandom; req1_a = $urandom;
            cycle(1);
            chk("stall_r0", 64'(req0_ready), 64'd0);
            chk("stall_r1", 64'(req1_ready), 64'd0);
        end
        resp_ready = 1'b1;
        req0_a = 32'd10; req0_b = 32'd20;
        cycle(1);
        chk("b2b_valid", 64'(resp_valid), 64'd1);
        chk("b2b_id", 64'(resp_id), 64'd0);
        chk("b2b_result", 64'(resp_result), 64'd30);

        // Asynchronous reset in the middle of the low clock phase while full.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(resp_valid), 64'd0);
        chk("arst_cnt0", 64'(grant_cnt0), 64'd0);
        chk("arst_cnt1", 64'(grant_cnt1), 64'd0);
        chk("arst_r0", 64'(req0_ready), 64'd0);
        chk("arst_r1", 64'(req1_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle(1);
        chk("arst_no_stale", 64'(resp_valid), 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 9) < 7);
            req0_op = rand_op(); req0_a = rand_operand(); req0_b = rand_operand();
            req1_op = rand_op(); req1_a = rand_operand(); req1_b = rand_operand();
            cycle(1);
        end

        // Counter saturation.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_reset();
        req0_valid = 1'b1;
        resp_ready = 1'b1;
        req0_op = 4'h2; req0_a = 32'd1; req0_b = 32'd2;
        for (int k = 0; k < 65540; k++) begin
            cycle(0);
        end
        chk("sat_cnt0", 64'(grant_cnt0), 64'hFFFF);
        chk("sat_cnt1", 64'(grant_cnt1), 64'd0);
        cycle(1);
        chk("sat_hold", 64'(grant_cnt0), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester k presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester k's operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  N  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  4  operation select.
REQ-008 SHALL have port resp_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port resp_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port resp_id  output  1  requester that issued the held result.
REQ-011 SHALL have port resp_result  output  N  ALU result.
REQ-012 SHALL have port resp_ovf  output  2  bit0 unsigned carry/borrow, bit1 signed overflow.
REQ-013 SHALL have port resp_illegal  output  1  held result came from an unsupported op.
REQ-014 SHALL have ports grant_cnt0 / grant_cnt1  output  16  accepted-operation counters.

Function
REQ-015 SHALL share one ALU between two requesters; at most one operation accepted per cycle.
REQ-016 SHALL implement a two-state FSM: EMPTY (resp_valid=0), FULL (resp_valid=1).
REQ-017 SHALL have can_accept = EMPTY, or FULL with resp_ready=1 in the same cycle.
REQ-018 SHALL grant, when exactly one req valid, that requester.
REQ-019 SHALL grant, when both valid, the requester not granted last (round-robin pointer).
REQ-020 SHALL update the pointer only on an accepted transfer.
REQ-021 SHALL drive reqk_ready = grant==k AND reqk_valid AND can_accept, combinationally; never both high.
REQ-022 SHALL produce resp_valid=1 in the cycle after acceptance (latency 1); the registered result carries resp_id = granted k.
REQ-023 SHALL: EMPTY + accept -> FULL; FULL + resp_ready + accept -> FULL with the new result; FULL + resp_ready + no accept -> EMPTY; FULL + !resp_ready -> FULL with all resp_* held stable.
REQ-024 SHALL compute op 4'b0000 = a AND b; ovf=00.
REQ-025 SHALL compute op 4'b0001 = a OR b; ovf=00.
REQ-026 SHALL compute op 4'b0010 = a+b mod 2^N; ovf[0]=carry out of bit N-1; ovf[1]=(a[N-1]==b[N-1]) AND (res[N-1]!=a[N-1]).
REQ-027 SHALL compute op 4'b0110 = a-b mod 2^N; ovf[0]=1 iff a<b unsigned; ovf[1]=(a[N-1]!=b[N-1]) AND (res[N-1]!=a[N-1]).
REQ-028 SHALL, for any other op, accept normally with result 0, ovf 00, resp_illegal 1; resp_illegal=0 for legal ops.
REQ-029 SHALL increment grant_cntk by 1 on each acceptance from k, saturating at 16'hFFFF.

Reset
REQ-030 SHALL on rst_n=0 immediately force: FSM EMPTY, resp_valid 0, resp_id 0, resp_result 0, resp_ovf 00, resp_illegal 0, grant counters 0, pointer such that req0 wins the first contention.
REQ-031 SHALL, if reset asserts while FULL, discard the held result; no response for it after reset release.
REQ-032 SHALL keep req0_ready=req1_ready=0 while rst_n=0.

Verification
REQ-033 SHALL cover: N=32, req0 ADD a=32'h7FFFFFFF b=1 -> next cycle resp_result 32'h80000000, ovf=10, resp_id 0.
REQ-034 SHALL cover: req1 SUB a=3 b=5 -> resp_result 32'hFFFFFFFE, ovf=01, resp_id 1; ADD a=32'hFFFFFFFF b=1 -> result 0, ovf=01.
REQ-035 SHALL cover: both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1 from reset; counters advance equally.
REQ-036 SHALL cover: resp_ready=0 for 3 cycles while FULL -> resp_* stable, both req_ready 0; release with new request -> back-to-back accept same cycle.
REQ-037 SHALL cover: op 4'b1111 -> resp_illegal 1, result 0; and rst_n low mid-FULL -> resp_valid 0 asynchronously, counters 0.
REQ-038 SHALL cover: 65540 accepts from req0 -> grant_cnt0 = 16'hFFFF.
